// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - FSM state encodings (plain localparams so older tools can read them)
//   - RV32I load/store funct3 encodings
//   - response error codes driven on o_rsp_err
package lsu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data path of the load/store unit.
//   i_we, i_funct3, i_addr_lo : operation being checked / steered
//   i_wdata                   : store data (rs2)
//   i_rdata                   : raw bus read word
//   o_illegal, o_misaligned   : legality checks
//   o_be, o_wdata             : byte enables and lane-replicated store data
//   o_rdata                   : extracted and sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane selected by the low address bits lands in bits [7:0].
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_illegal = 1'b1;
    case (i_funct3)
      F3_LB, F3_LH, F3_LW: o_illegal = 1'b0;
      F3_LBU, F3_LHU:      o_illegal = i_we;   // unsigned forms exist only for loads
      default:             o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b01:   o_misaligned = i_addr_lo[0];
      2'b10:   o_misaligned = (i_addr_lo != 2'b00);
      default: o_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    if (i_we) begin
      case (i_funct3[1:0])
        2'b00: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_rdata = {24'h0, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_rdata = {16'h0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage to a word-wide, variable-latency
// data bus. Stalls the core while a transaction is outstanding and returns a
// one-cycle response with extended load data or an error code.
//   clk, reset                     : clock, async active-high reset
//   i_req_*                        : memory op from execute (held while o_stall)
//   o_stall                        : core must hold PC/request
//   o_rsp_valid/o_rsp_rdata/o_rsp_err : completion pulse, data, error code
//   o_mem_* / i_mem_*              : bus request side and grant/read-data side
//
// state | meaning
// IDLE  | waiting for a request; legality checked on the live inputs
// REQ   | bus request asserted until grant
// WAIT  | load granted, waiting for read data
// RESP  | one-cycle response, always back to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       r_state;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  lsu_err_e         r_err;
  logic [31:0]      r_rdata;

  logic             w_idle;
  logic             w_in_req;
  logic             w_in_resp;
  logic             w_sel_we;
  logic [2:0]       w_sel_funct3;
  logic [1:0]       w_sel_addr_lo;
  logic             w_illegal;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [31:0]      w_lane_wdata;
  logic [31:0]      w_load_data;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_limit;

  assign w_idle    = (r_state == S_IDLE);
  assign w_in_req  = (r_state == S_REQ);
  assign w_in_resp = (r_state == S_RESP);

  // One aligner serves both phases: live inputs are checked in IDLE, the
  // captured request drives steering/extraction afterwards.
  assign w_sel_we      = w_idle ? i_req_we          : r_we;
  assign w_sel_funct3  = w_idle ? i_req_funct3      : r_funct3;
  assign w_sel_addr_lo = w_idle ? i_req_addr[1:0]   : r_addr[1:0];

  lsu_align u_align (
    .i_we         (w_sel_we),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr_lo),
    .i_wdata      (r_wdata),
    .i_rdata      (i_mem_rdata),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_lane_wdata),
    .o_rdata      (w_load_data)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_limit   = (w_cnt_inc == CNT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_cnt    <= '0;
      r_err    <= ERR_OK;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_rdata  <= 32'h0;
            if (w_illegal) begin
              r_err   <= ERR_ILLEGAL;
              r_state <= S_RESP;
            end else if (w_misaligned) begin
              r_err   <= ERR_MISALIGN;
              r_state <= S_RESP;
            end else begin
              r_err   <= ERR_OK;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_inc;
          // A grant on the limit cycle still counts as success.
          if (i_mem_gnt) begin
            r_state <= r_we ? S_RESP : S_WAIT;
          end else if (w_limit) begin
            r_err   <= ERR_TIMEOUT;
            r_state <= S_RESP;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (i_mem_rvalid) begin
            r_rdata <= w_load_data;
            r_state <= S_RESP;
          end else if (w_limit) begin
            r_err   <= ERR_TIMEOUT;
            r_state <= S_RESP;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall     = (w_idle & i_req_valid) | w_in_req | (r_state == S_WAIT);
  assign o_rsp_valid = w_in_resp;
  assign o_rsp_rdata = w_in_resp ? r_rdata : 32'h0;
  assign o_rsp_err   = w_in_resp ? r_err : ERR_OK;

  // Bus fields are only driven while the request is on the bus.
  assign o_mem_req   = w_in_req;
  assign o_mem_we    = w_in_req & r_we;
  assign o_mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_be    = w_in_req ? w_be : 4'b0000;
  assign o_mem_wdata = w_in_req ? w_lane_wdata : 32'h0;

endmodule
